// File: rtl/player_action_scheduler.sv
`default_nettype none
// ============================================================================
//  Module      : player_action_scheduler
//  Description : Rate-limited joystick column moves and cooldown-gated shot
//                offers (column + LFSR colour) over a valid/ready handshake.
//  Revision    : 1.0  initial release
// ============================================================================
module player_action_scheduler #(
    parameter int unsigned MAX_POS       = 7,
    parameter int unsigned MOVE_REPEAT   = 4,
    parameter int unsigned SHOT_COOLDOWN = 6,
    parameter logic [7:0]  LFSR_SEED     = 8'hA5
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       en,
    input  logic       tick,
    input  logic [3:0] jstkPos,
    output logic [2:0] player_pos,
    output logic       move_pulse,
    output logic       shot_valid,
    output logic [2:0] shot_pos,
    output logic [1:0] shot_color,
    input  logic       shot_ready,
    output logic       busy
);

    localparam logic [2:0] c_max_pos   = 3'(MAX_POS);
    localparam logic [3:0] c_move_rep  = 4'(MOVE_REPEAT);
    localparam logic [3:0] c_cooldown  = 4'(SHOT_COOLDOWN);
    localparam logic [2:0] c_reset_pos = 3'd1;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_OFFER = 2'd1,
        S_COOL  = 2'd2
    } state_t;

    // ------------------------------------------------------------------
    // Input decode and edge detection
    // ------------------------------------------------------------------
    logic w_fire;
    logic w_left;
    logic w_right;
    logic w_unused_jstk;

    assign w_fire        = jstkPos[0];
    assign w_left        = jstkPos[2];
    assign w_right       = jstkPos[3];
    assign w_unused_jstk = jstkPos[1];

    logic r_fire_q;
    logic r_left_q;
    logic r_right_q;

    // Direction is resolved before edge detection so that a hand-over from
    // left to a still-held right is seen as a fresh right press.
    logic w_dir_l;
    logic w_dir_r;
    logic w_prev_dir_l;
    logic w_prev_dir_r;
    logic w_dir_edge;
    logic w_fire_edge;

    assign w_dir_l      = w_left;
    assign w_dir_r      = w_right & ~w_left;
    assign w_prev_dir_l = r_left_q;
    assign w_prev_dir_r = r_right_q & ~r_left_q;
    assign w_dir_edge   = (w_dir_l & ~w_prev_dir_l) | (w_dir_r & ~w_prev_dir_r);
    assign w_fire_edge  = w_fire & ~r_fire_q;

    // ------------------------------------------------------------------
    // Move repeat timer and position
    // ------------------------------------------------------------------
    logic [3:0] r_rep_cnt;
    logic [3:0] w_rep_nxt;
    logic       w_move_req;
    logic [2:0] r_pos;
    logic [2:0] w_pos_nxt;
    logic       w_moved;
    logic       r_move_pulse;

    always_comb begin
        w_rep_nxt  = r_rep_cnt;
        w_move_req = 1'b0;
        if (!(w_dir_l | w_dir_r)) begin
            w_rep_nxt = 4'd0;
        end else if (en) begin
            if (w_dir_edge) begin
                w_move_req = 1'b1;
                w_rep_nxt  = c_move_rep;
            end else if (tick && (r_rep_cnt != 4'd0)) begin
                if (r_rep_cnt == 4'd1) begin
                    w_move_req = 1'b1;
                    w_rep_nxt  = c_move_rep;
                end else begin
                    w_rep_nxt = r_rep_cnt - 4'd1;
                end
            end
        end
    end

    always_comb begin
        w_pos_nxt = r_pos;
        if (w_move_req) begin
            if (w_dir_l) begin
                if (r_pos < c_max_pos) begin
                    w_pos_nxt = r_pos + 3'd1;
                end
            end else if (r_pos != 3'd0) begin
                w_pos_nxt = r_pos - 3'd1;
            end
        end
    end

    assign w_moved = (w_pos_nxt != r_pos);

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_fire_q     <= 1'b0;
            r_left_q     <= 1'b0;
            r_right_q    <= 1'b0;
            r_rep_cnt    <= 4'd0;
            r_pos        <= c_reset_pos;
            r_move_pulse <= 1'b0;
        end else begin
            r_fire_q     <= w_fire;
            r_left_q     <= w_left;
            r_right_q    <= w_right;
            r_rep_cnt    <= w_rep_nxt;
            r_pos        <= w_pos_nxt;
            r_move_pulse <= w_moved;
        end
    end

    // ------------------------------------------------------------------
    // Colour LFSR: x^8 + x^6 + x^5 + x^4 + 1, free running
    // ------------------------------------------------------------------
    logic [7:0] r_lfsr;
    logic       w_lfsr_fb;
    logic [1:0] w_color;

    assign w_lfsr_fb = r_lfsr[7] ^ r_lfsr[5] ^ r_lfsr[4] ^ r_lfsr[3];
    assign w_color   = (r_lfsr[1:0] == 2'b11) ? 2'b00 : r_lfsr[1:0];

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_lfsr <= LFSR_SEED;
        end else begin
            r_lfsr <= {r_lfsr[6:0], w_lfsr_fb};
        end
    end

    // ------------------------------------------------------------------
    // Shot FSM
    // ------------------------------------------------------------------
    state_t     r_state;
    state_t     w_state_nxt;
    logic [3:0] r_cd_cnt;
    logic [3:0] w_cd_nxt;
    logic       w_latch_shot;
    logic [2:0] r_shot_pos;
    logic [1:0] r_shot_color;

    always_comb begin
        w_state_nxt  = r_state;
        w_cd_nxt     = r_cd_cnt;
        w_latch_shot = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (en && w_fire_edge) begin
                    w_latch_shot = 1'b1;
                    w_state_nxt  = S_OFFER;
                end
            end
            // The offer is held regardless of en until the bullet field takes it.
            S_OFFER: begin
                if (shot_ready) begin
                    w_state_nxt = S_COOL;
                    w_cd_nxt    = c_cooldown;
                end
            end
            S_COOL: begin
                if (en && tick) begin
                    if (r_cd_cnt <= 4'd1) begin
                        w_state_nxt = S_IDLE;
                        w_cd_nxt    = 4'd0;
                    end else begin
                        w_cd_nxt = r_cd_cnt - 4'd1;
                    end
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
                w_cd_nxt    = 4'd0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state      <= S_IDLE;
            r_cd_cnt     <= 4'd0;
            r_shot_pos   <= 3'd0;
            r_shot_color <= 2'd0;
        end else begin
            r_state  <= w_state_nxt;
            r_cd_cnt <= w_cd_nxt;
            if (w_latch_shot) begin
                r_shot_pos   <= r_pos;
                r_shot_color <= w_color;
            end
        end
    end

    assign player_pos = r_pos;
    assign move_pulse = r_move_pulse;
    assign shot_valid = (r_state == S_OFFER);
    assign shot_pos   = r_shot_pos;
    assign shot_color = r_shot_color;
    assign busy       = (r_state != S_IDLE);

endmodule
`default_nettype wire

// File: tb/tb_player_action_scheduler.sv
`default_nettype none
// ============================================================================
//  Module      : tb_player_action_scheduler
//  Description : Self-checking bench for player_action_scheduler.
//  Revision    : 1.0  initial release
// ============================================================================
`timescale 1ns/1ps
module tb_player_action_scheduler;

    localparam int         MAX_POS       = 7;
    localparam int         MOVE_REPEAT   = 4;
    localparam int         SHOT_COOLDOWN = 6;
    localparam logic [7:0] SEED          = 8'hA5;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       en = 1'b0;
    logic       tick = 1'b0;
    logic       shot_ready = 1'b0;
    logic [3:0] jstk = 4'd0;
    logic [2:0] player_pos;
    logic [2:0] shot_pos;
    logic [1:0] shot_color;
    logic       move_pulse;
    logic       shot_valid;
    logic       busy;

    int n_cmp = 0;
    int n_bad = 0;
    int since_rst = 0;
    int m_pos = 1;

    player_action_scheduler #(
        .MAX_POS(MAX_POS), .MOVE_REPEAT(MOVE_REPEAT),
        .SHOT_COOLDOWN(SHOT_COOLDOWN), .LFSR_SEED(SEED)
    ) dut (
        .clk(clk), .rst(rst), .en(en), .tick(tick), .jstkPos(jstk),
        .player_pos(player_pos), .move_pulse(move_pulse), .shot_valid(shot_valid),
        .shot_pos(shot_pos), .shot_color(shot_color), .shot_ready(shot_ready),
        .busy(busy)
    );

    always #5 clk = ~clk;

    // Number of clock edges seen since reset was released = LFSR sequence index.
    always @(posedge clk) since_rst <= rst ? since_rst + 1 : 0;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [1:0] color_at(input int n);
        logic [7:0] l;
        l = SEED;
        for (int i = 0; i < n; i++) l = {l[6:0], l[7] ^ l[5] ^ l[4] ^ l[3]};
        return (l[1:0] == 2'b11) ? 2'b00 : l[1:0];
    endfunction

    task automatic test_reset();
        rst = 1'b0; en = 1'b1; jstk = 4'd0; tick = 1'b0; shot_ready = 1'b0;
        repeat (3) step();
        n_cmp++; if (player_pos !== 3'd1) begin n_bad++; $display("FAIL reset_pos: got %0d want 1", player_pos); end
        n_cmp++; if (shot_valid !== 1'b0) begin n_bad++; $display("FAIL reset_valid: got %b want 0", shot_valid); end
        n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL reset_busy: got %b want 0", busy); end
        n_cmp++; if (move_pulse !== 1'b0) begin n_bad++; $display("FAIL reset_pulse: got %b want 0", move_pulse); end
        n_cmp++; if (shot_pos !== 3'd0 || shot_color !== 2'd0) begin
            n_bad++; $display("FAIL reset_shot: got pos %0d col %0d want 0 0", shot_pos, shot_color); end
        rst = 1'b1;
        repeat (5) step();
        n_cmp++; if (player_pos !== 3'd1 || move_pulse !== 1'b0 || shot_valid !== 1'b0 || busy !== 1'b0) begin
            n_bad++; $display("FAIL reset_idle: got pos %0d pulse %b valid %b busy %b want 1 0 0 0",
                              player_pos, move_pulse, shot_valid, busy); end
    endtask

    task automatic test_move_hold();
        int ticks;
        int exp_p;
        int prev_p;
        jstk[2] = 1'b1; step();
        n_cmp++; if (player_pos !== 3'd2) begin n_bad++; $display("FAIL left_edge_pos: got %0d want 2", player_pos); end
        n_cmp++; if (move_pulse !== 1'b1) begin n_bad++; $display("FAIL left_edge_pulse: got %b want 1", move_pulse); end
        jstk[2] = 1'b0; step();
        n_cmp++; if (move_pulse !== 1'b0 || player_pos !== 3'd2) begin
            n_bad++; $display("FAIL left_pulse_width: got pulse %b pos %0d want 0 2", move_pulse, player_pos); end
        // Hold left: the press moves at once, then one step per MOVE_REPEAT ticks.
        jstk[2] = 1'b1; step();
        n_cmp++; if (player_pos !== 3'd3 || move_pulse !== 1'b1) begin
            n_bad++; $display("FAIL hold_edge: got pos %0d pulse %b want 3 1", player_pos, move_pulse); end
        ticks = 0; prev_p = 3;
        for (int c = 0; c < 120; c++) begin
            tick = (c % 3 == 0);
            step();
            if (tick) ticks++;
            exp_p = 3 + ticks / MOVE_REPEAT;
            if (exp_p > MAX_POS) exp_p = MAX_POS;
            n_cmp++; if (player_pos !== 3'(exp_p) || move_pulse !== (exp_p != prev_p)) begin
                n_bad++; $display("FAIL hold_repeat tick %0d: got pos %0d pulse %b want %0d %b",
                                  ticks, player_pos, move_pulse, exp_p, exp_p != prev_p); end
            prev_p = exp_p;
        end
        tick = 1'b0; jstk[2] = 1'b0; step();
    endtask

    task automatic test_both_dirs();
        repeat (4) begin
            jstk[3] = 1'b1; step();
            jstk[3] = 1'b0; step();
        end
        n_cmp++; if (player_pos !== 3'd3) begin n_bad++; $display("FAIL right_steps: got %0d want 3", player_pos); end
        jstk[2] = 1'b1; jstk[3] = 1'b1; step();
        n_cmp++; if (player_pos !== 3'd4 || move_pulse !== 1'b1) begin
            n_bad++; $display("FAIL both_left_prio: got pos %0d pulse %b want 4 1", player_pos, move_pulse); end
        jstk[2] = 1'b0; step();
        n_cmp++; if (player_pos !== 3'd3 || move_pulse !== 1'b1) begin
            n_bad++; $display("FAIL switch_right: got pos %0d pulse %b want 3 1", player_pos, move_pulse); end
        step();
        n_cmp++; if (player_pos !== 3'd3 || move_pulse !== 1'b0) begin
            n_bad++; $display("FAIL right_held: got pos %0d pulse %b want 3 0", player_pos, move_pulse); end
        jstk = 4'd0; step();
    endtask

    task automatic test_offer_hold();
        logic [1:0] exp_c;
        repeat (2) begin
            jstk[2] = 1'b1; step();
            jstk[2] = 1'b0; step();
        end
        n_cmp++; if (player_pos !== 3'd5) begin n_bad++; $display("FAIL offer_setup_pos: got %0d want 5", player_pos); end
        jstk[0] = 1'b1;
        exp_c = color_at(since_rst);
        n_cmp++; if (shot_valid !== 1'b0) begin n_bad++; $display("FAIL offer_early: got %b want 0", shot_valid); end
        step();
        jstk[0] = 1'b0;
        n_cmp++; if (shot_valid !== 1'b1 || busy !== 1'b1) begin
            n_bad++; $display("FAIL offer_rise: got valid %b busy %b want 1 1", shot_valid, busy); end
        n_cmp++; if (shot_pos !== 3'd5 || shot_color !== exp_c) begin
            n_bad++; $display("FAIL offer_data: got pos %0d col %0d want 5 %0d", shot_pos, shot_color, exp_c); end
        for (int c = 0; c < 10; c++) begin
            jstk[3] = (c == 2 || c == 5);
            en = (c < 8);
            step();
            n_cmp++; if (shot_valid !== 1'b1 || shot_pos !== 3'd5 || shot_color !== exp_c) begin
                n_bad++; $display("FAIL offer_stable c%0d: got valid %b pos %0d col %0d want 1 5 %0d",
                                  c, shot_valid, shot_pos, shot_color, exp_c); end
        end
        jstk = 4'd0; en = 1'b1;
        n_cmp++; if (player_pos !== 3'd3) begin n_bad++; $display("FAIL offer_moves: got %0d want 3", player_pos); end
    endtask

    task automatic test_accept_cooldown();
        logic [1:0] exp_c;
        shot_ready = 1'b1; step(); shot_ready = 1'b0;
        n_cmp++; if (shot_valid !== 1'b0 || busy !== 1'b1) begin
            n_bad++; $display("FAIL accept: got valid %b busy %b want 0 1", shot_valid, busy); end
        for (int i = 1; i <= SHOT_COOLDOWN; i++) begin
            jstk[0] = 1'b1; step();
            n_cmp++; if (shot_valid !== 1'b0) begin
                n_bad++; $display("FAIL cool_fire_ignored %0d: got %b want 0", i, shot_valid); end
            jstk[0] = 1'b0; tick = 1'b1; step(); tick = 1'b0;
            n_cmp++; if (busy !== (i < SHOT_COOLDOWN)) begin
                n_bad++; $display("FAIL cool_busy %0d: got %b want %b", i, busy, i < SHOT_COOLDOWN); end
        end
        jstk[0] = 1'b1;
        exp_c = color_at(since_rst);
        step(); jstk[0] = 1'b0;
        n_cmp++; if (shot_valid !== 1'b1 || shot_color !== exp_c || shot_pos !== 3'd3) begin
            n_bad++; $display("FAIL post_cool_fire: got valid %b col %0d pos %0d want 1 %0d 3",
                              shot_valid, shot_color, shot_pos, exp_c); end
        shot_ready = 1'b1; step(); shot_ready = 1'b0;
        // Fire held through the whole cooldown must not re-fire on return to idle.
        jstk[0] = 1'b1;
        repeat (SHOT_COOLDOWN) begin tick = 1'b1; step(); tick = 1'b0; step(); end
        repeat (3) step();
        n_cmp++; if (shot_valid !== 1'b0 || busy !== 1'b0) begin
            n_bad++; $display("FAIL held_fire_no_refire: got valid %b busy %b want 0 0", shot_valid, busy); end
        jstk[0] = 1'b0; step();
    endtask

    task automatic test_enable();
        en = 1'b0; jstk[0] = 1'b1; jstk[2] = 1'b1; step();
        n_cmp++; if (shot_valid !== 1'b0 || busy !== 1'b0 || player_pos !== 3'd3 || move_pulse !== 1'b0) begin
            n_bad++; $display("FAIL en_low_freeze: got valid %b busy %b pos %0d pulse %b want 0 0 3 0",
                              shot_valid, busy, player_pos, move_pulse); end
        jstk = 4'd0; step(); en = 1'b1;
    endtask

    task automatic test_random_moves();
        int prev_dir;
        int dir;
        int held;
        logic exp_pulse;
        rst = 1'b0; jstk = 4'd0; tick = 1'b0; step(); rst = 1'b1;
        m_pos = 1; prev_dir = 0; held = 0;
        for (int c = 0; c < 300; c++) begin
            if ($urandom_range(0, 5) == 0) jstk[2] = ~jstk[2];
            if ($urandom_range(0, 5) == 0) jstk[3] = ~jstk[3];
            tick = ($urandom_range(0, 2) == 0);
            dir = jstk[2] ? 1 : (jstk[3] ? 2 : 0);
            exp_pulse = 1'b0;
            if (dir == 0) held = 0;
            else if (dir != prev_dir || (tick && ((held + 1) % MOVE_REPEAT == 0))) begin
                if (dir != prev_dir) held = 0; else held++;
                if (dir == 1 && m_pos < MAX_POS) begin m_pos++; exp_pulse = 1'b1; end
                if (dir == 2 && m_pos > 0) begin m_pos--; exp_pulse = 1'b1; end
            end else if (tick) held++;
            prev_dir = dir;
            step();
            n_cmp++; if (player_pos !== 3'(m_pos) || move_pulse !== exp_pulse) begin
                n_bad++; $display("FAIL rand_move c%0d: got pos %0d pulse %b want %0d %b",
                                  c, player_pos, move_pulse, m_pos, exp_pulse); end
        end
        jstk = 4'd0; tick = 1'b0; step();
    endtask

    task automatic test_colors();
        logic [1:0] exp_c;
        for (int s = 0; s < 20; s++) begin
            repeat ($urandom_range(0, 7)) step();
            jstk[0] = 1'b1;
            exp_c = color_at(since_rst);
            step(); jstk[0] = 1'b0;
            n_cmp++; if (shot_valid !== 1'b1 || shot_color !== exp_c || shot_pos !== 3'(m_pos)) begin
                n_bad++; $display("FAIL color shot %0d: got valid %b col %0d pos %0d want 1 %0d %0d",
                                  s, shot_valid, shot_color, shot_pos, exp_c, m_pos); end
            n_cmp++; if (shot_color === 2'd3) begin
                n_bad++; $display("FAIL color_not3 shot %0d: got %0d want 0..2", s, shot_color); end
            repeat ($urandom_range(0, 4)) step();
            shot_ready = 1'b1; step(); shot_ready = 1'b0;
            repeat (SHOT_COOLDOWN) begin tick = 1'b1; step(); end
            tick = 1'b0;
            n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL color_cool %0d: got busy %b want 0", s, busy); end
        end
    endtask

    task automatic test_reset_mid_offer();
        jstk[0] = 1'b1; step(); jstk[0] = 1'b0;
        n_cmp++; if (shot_valid !== 1'b1) begin n_bad++; $display("FAIL midrst_offer: got %b want 1", shot_valid); end
        rst = 1'b0; step();
        n_cmp++; if (shot_valid !== 1'b0 || busy !== 1'b0 || player_pos !== 3'd1) begin
            n_bad++; $display("FAIL midrst_drop: got valid %b busy %b pos %0d want 0 0 1", shot_valid, busy, player_pos); end
        rst = 1'b1; repeat (2) step();
        n_cmp++; if (shot_valid !== 1'b0) begin n_bad++; $display("FAIL midrst_after: got %b want 0", shot_valid); end
    endtask

    initial begin
        test_reset();
        test_move_hold();
        test_both_dirs();
        test_offer_hold();
        test_accept_cooldown();
        test_enable();
        test_random_moves();
        test_colors();
        test_reset_mid_offer();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
